axi_lite_burst_master: RTL



---
 rtl/axi_lite_burst_master.sv | 282 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_lite_burst_master.sv
// AXI4-Lite burst master: splits one command of up to MAX_BEATS narrow beats
// into single AXI4-Lite transactions, with per-beat alignment checks, lane
// placement, response checking and a per-beat wait timeout.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   cmd_*                      command handshake and fields (write/inc/size/len/addr/wdata)
//   done, status               one-cycle completion pulse and result code
//   rd_data, rd_count          packed read bytes and count of OKAY read bytes
//   busy_early                 current beat has waited at least BUSY_THRESHOLD cycles
//   m_aw*/m_w*/m_b*/m_ar*/m_r* AXI4-Lite master channels
module axi_lite_burst_master #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned MAX_BEATS      = 16,
    parameter int unsigned AXI_TIMEOUT    = 2500,
    parameter int unsigned BUSY_THRESHOLD = 250,
    localparam int unsigned LEN_W  = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1,
    localparam int unsigned BUF_W  = MAX_BEATS * DATA_WIDTH,
    localparam int unsigned STRB_W = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic                  cmd_inc,
    input  logic [1:0]            cmd_size,
    input  logic [LEN_W-1:0]      cmd_len,
    input  logic [31:0]           cmd_addr,
    input  logic [BUF_W-1:0]      cmd_wdata,
    output logic                  done,
    output logic [7:0]            status,
    output logic [BUF_W-1:0]      rd_data,
    output logic [7:0]            rd_count,
    output logic                  busy_early,
    output logic [31:0]           m_awaddr,
    output logic [2:0]            m_awprot,
    output logic                  m_awvalid,
    input  logic                  m_awready,
    output logic [DATA_WIDTH-1:0] m_wdata,
    output logic [STRB_W-1:0]     m_wstrb,
    output logic                  m_wvalid,
    input  logic                  m_wready,
    input  logic [1:0]            m_bresp,
    input  logic                  m_bvalid,
    output logic                  m_bready,
    output logic [31:0]           m_araddr,
    output logic [2:0]            m_arprot,
    output logic                  m_arvalid,
    input  logic                  m_arready,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    input  logic [1:0]            m_rresp,
    input  logic                  m_rvalid,
    output logic                  m_rready
);

    localparam int unsigned OFF_W  = $clog2(STRB_W);
    localparam int unsigned NBYTES = BUF_W / 8;
    localparam int unsigned WAIT_W = $clog2(AXI_TIMEOUT + 1);

    localparam logic [7:0] StatOk       = 8'h00;
    localparam logic [7:0] StatMisalign = 8'h03;
    localparam logic [7:0] StatTimeout  = 8'h04;
    localparam logic [7:0] StatSlvErr   = 8'h05;
    localparam logic [7:0] StatBusy     = 8'h06;
    localparam logic [7:0] StatSize     = 8'h07;

    typedef enum logic [2:0] {
        StIdle, StCheck, StWrAwW, StWrResp, StRdAddr, StRdData, StNext, StDone
    } state_e;

    state_e              state_q, state_d;
    logic                write_q, write_d, inc_q, inc_d;
    logic [1:0]          size_q, size_d;
    logic [LEN_W-1:0]    len_q, len_d, beat_q, beat_d;
    logic [31:0]         addr_q, addr_d;
    logic [BUF_W-1:0]    wdata_q, wdata_d, rd_data_q, rd_data_d;
    logic [7:0]          status_q, status_d, rd_count_q, rd_count_d;
    logic                aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                busy_seen_q, busy_seen_d;

    logic [DATA_WIDTH-1:0] wdata_beat;
    logic [STRB_W-1:0]     wstrb_beat;
    int unsigned           nbytes, off, base;
    logic                  in_wait, timeout, aw_now, w_now;
    logic [7:0]            timeout_code;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            write_q     <= 1'b0;
            inc_q       <= 1'b0;
            size_q      <= '0;
            len_q       <= '0;
            beat_q      <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rd_data_q   <= '0;
            status_q    <= StatOk;
            rd_count_q  <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            wait_q      <= '0;
            busy_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            inc_q       <= inc_d;
            size_q      <= size_d;
            len_q       <= len_d;
            beat_q      <= beat_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rd_data_q   <= rd_data_d;
            status_q    <= status_d;
            rd_count_q  <= rd_count_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            wait_q      <= wait_d;
            busy_seen_q <= busy_seen_d;
        end
    end

    // Beat geometry and write lane placement.
    always_comb begin
        nbytes     = 32'd1 << size_q;
        off        = 32'(addr_q[OFF_W-1:0]);
        base       = 32'(beat_q) * nbytes;
        wdata_beat = '0;
        wstrb_beat = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            if (k < nbytes && off + k < STRB_W && base + k < NBYTES) begin
                wdata_beat[8*(off+k) +: 8] = wdata_q[8*(base+k) +: 8];
                wstrb_beat[off+k]          = 1'b1;
            end
        end
    end

    assign in_wait      = (state_q == StWrAwW) || (state_q == StWrResp) ||
                          (state_q == StRdAddr) || (state_q == StRdData);
    assign busy_early   = in_wait && (wait_q >= WAIT_W'(BUSY_THRESHOLD));
    assign timeout      = in_wait && (wait_q >= WAIT_W'(AXI_TIMEOUT));
    // BUSY if the early-busy flag was seen at any point in this beat.
    assign timeout_code = (busy_seen_q || busy_early) ? StatBusy : StatTimeout;

    assign aw_now = aw_done_q || (m_awvalid && m_awready);
    assign w_now  = w_done_q || (m_wvalid && m_wready);

    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        inc_d       = inc_q;
        size_d      = size_q;
        len_d       = len_q;
        beat_d      = beat_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rd_data_d   = rd_data_q;
        status_d    = status_q;
        rd_count_d  = rd_count_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        busy_seen_d = busy_seen_q || busy_early;
        wait_d      = (in_wait && !timeout) ? wait_q + WAIT_W'(1) : wait_q;

        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    write_d    = cmd_write;
                    inc_d      = cmd_inc;
                    size_d     = cmd_size;
                    len_d      = cmd_len;
                    addr_d     = cmd_addr;
                    wdata_d    = cmd_wdata;
                    beat_d     = '0;
                    status_d   = StatOk;
                    rd_count_d = '0;
                    rd_data_d  = '0;
                    state_d    = StCheck;
                end
            end
            StCheck: begin
                busy_seen_d = 1'b0;
                aw_done_d   = 1'b0;
                w_done_d    = 1'b0;
                wait_d      = '0;
                if (size_q == 2'd3 && DATA_WIDTH == 32) begin
                    status_d = StatSize;
                    state_d  = StDone;
                end else if ((addr_q & (nbytes - 32'd1)) != 32'd0) begin
                    status_d = StatMisalign;
                    state_d  = StDone;
                end else begin
                    state_d = write_q ? StWrAwW : StRdAddr;
                end
            end
            StWrAwW: begin
                aw_done_d = aw_now;
                w_done_d  = w_now;
                if (aw_now && w_now) begin
                    wait_d  = '0;
                    state_d = StWrResp;
                end else if (timeout) begin
                    status_d = timeout_code;
                    state_d  = StDone;
                end
            end
            StWrResp: begin
                if (m_bvalid) begin
                    if (m_bresp != 2'b00) begin
                        status_d = StatSlvErr;
                        state_d  = StDone;
                    end else begin
                        state_d = (beat_q == len_q) ? StDone : StNext;
                    end
                end else if (timeout) begin
                    status_d = timeout_code;
                    state_d  = StDone;
                end
            end
            StRdAddr: begin
                if (m_arready) begin
                    wait_d  = '0;
                    state_d = StRdData;
                end else if (timeout) begin
                    status_d = timeout_code;
                    state_d  = StDone;
                end
            end
            StRdData: begin
                if (m_rvalid) begin
                    // Bytes land in rd_data even for an erroring beat.
                    for (int unsigned k = 0; k < 8; k++) begin
                        if (k < nbytes && off + k < STRB_W && base + k < NBYTES) begin
                            rd_data_d[8*(base+k) +: 8] = m_rdata[8*(off+k) +: 8];
                        end
                    end
                    if (m_rresp != 2'b00) begin
                        status_d = StatSlvErr;
                        state_d  = StDone;
                    end else begin
                        rd_count_d = rd_count_q + 8'(nbytes);
                        state_d    = (beat_q == len_q) ? StDone : StNext;
                    end
                end else if (timeout) begin
                    status_d = timeout_code;
                    state_d  = StDone;
                end
            end
            StNext: begin
                beat_d = beat_q + LEN_W'(1);
                if (inc_q) begin
                    addr_d = addr_q + nbytes;
                end
                state_d = StCheck;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign cmd_ready = (state_q == StIdle);
    assign done      = (state_q == StDone);
    assign status    = status_q;
    assign rd_data   = rd_data_q;
    assign rd_count  = rd_count_q;

    assign m_awaddr  = addr_q;
    assign m_awprot  = 3'b000;
    assign m_awvalid = (state_q == StWrAwW) && !aw_done_q;
    assign m_wdata   = wdata_beat;
    assign m_wstrb   = wstrb_beat;
    assign m_wvalid  = (state_q == StWrAwW) && !w_done_q;
    assign m_bready  = (state_q == StWrResp);
    assign m_araddr  = addr_q;
    assign m_arprot  = 3'b000;
    assign m_arvalid = (state_q == StRdAddr);
    assign m_rready  = (state_q == StRdData);

endmodule
